oam_dma_arbiter: RTL and testbench

OAM_DMA_ARBITER -- requirements
Module: oam_dma_arbiter

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/oam_dma_arbiter_if.sv | 26 ++
 rtl/oam_dma_arbiter.sv | 127 ++++++++++++
 tb/tb_oam_dma_arbiter.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-side types and address map constants for the OAM DMA arbiter.
package cpu_pkg;

    typedef enum logic [1:0] {
        DmaIdle,
        DmaSetup,
        DmaActive
    } dma_state_e;

    localparam logic [15:0] DMA_REG_ADDR    = 16'hFF46;
    localparam logic [15:0] HRAM_BASE       = 16'hFF80;
    localparam logic [15:0] HRAM_LAST       = 16'hFFFE;
    localparam int unsigned OAM_LEN_DEFAULT = 160;

    // Sources in echo RAM (0xE0-0xFF) alias back onto work RAM.
    function automatic logic [7:0] dma_src_eff(input logic [7:0] src);
        return (src >= 8'hE0) ? src - 8'h20 : src;
    endfunction

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// Byte-wide memory access bundle used for both the CPU side and the system bus.
interface oam_dma_arbiter_if;

    logic [15:0] addr;
    logic        enable;
    logic        write;
    logic [7:0]  wdata;
    logic [7:0]  rdata;

    modport master (
        output addr,
        output enable,
        output write,
        output wdata,
        input  rdata
    );

    modport slave (
        input  addr,
        input  enable,
        input  write,
        input  wdata,
        output rdata
    );

endinterface

// File: rtl/oam_dma_arbiter.sv
// Routes CPU accesses to HRAM, the DMA register or the system bus, and runs the
// OAM DMA engine that takes over the system bus for one byte per M-cycle.
module oam_dma_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned OAM_LEN = OAM_LEN_DEFAULT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [1:0]               t_cycle,
    oam_dma_arbiter_if.slave         cpu,
    oam_dma_arbiter_if.master        bus,
    output logic [6:0]               hram_addr,
    output logic                     hram_enable,
    output logic                     hram_write,
    input  logic [7:0]               hram_rdata,
    output logic [7:0]               oam_addr,
    output logic                     oam_write,
    output logic [7:0]               oam_wdata,
    output logic                     dma_active
);

    localparam logic [7:0] IDX_LAST = 8'(OAM_LEN - 1);

    dma_state_e state_q;
    logic [7:0] idx_q;
    logic [7:0] dma_src_q;
    logic       restart_q;

    logic m_end;
    logic is_dma_reg;
    logic is_hram;
    logic is_bus;
    logic dma_wr;

    assign m_end      = (t_cycle == 2'd3);
    assign is_dma_reg = (cpu.addr == DMA_REG_ADDR);
    assign is_hram    = (cpu.addr >= HRAM_BASE) && (cpu.addr <= HRAM_LAST);
    assign is_bus     = !is_dma_reg && !is_hram;
    assign dma_wr     = cpu.enable && cpu.write && is_dma_reg && m_end;

    // A SETUP entered by restart keeps the bus owned by the DMA.
    assign dma_active = (state_q == DmaActive) || ((state_q == DmaSetup) && restart_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= DmaIdle;
            idx_q     <= 8'h00;
            dma_src_q <= 8'hFF;
            restart_q <= 1'b0;
        end else begin
            if (dma_wr) begin
                dma_src_q <= cpu.wdata;
            end
            if (m_end) begin
                unique case (state_q)
                    DmaIdle: begin
                        if (dma_wr) begin
                            state_q   <= DmaSetup;
                            restart_q <= 1'b0;
                        end
                    end
                    DmaSetup: begin
                        // A register write here repeats SETUP with the new source.
                        if (!dma_wr) begin
                            state_q   <= DmaActive;
                            idx_q     <= 8'h00;
                            restart_q <= 1'b0;
                        end
                    end
                    DmaActive: begin
                        if (dma_wr) begin
                            state_q   <= DmaSetup;
                            restart_q <= 1'b1;
                            idx_q     <= 8'h00;
                        end else if (idx_q == IDX_LAST) begin
                            state_q   <= DmaIdle;
                            idx_q     <= 8'h00;
                            restart_q <= 1'b0;
                        end else begin
                            idx_q <= idx_q + 8'h01;
                        end
                    end
                    default: begin
                        state_q <= DmaIdle;
                    end
                endcase
            end
        end
    end

    always_comb begin
        hram_addr   = cpu.addr[6:0];
        hram_enable = cpu.enable && is_hram;
        hram_write  = cpu.enable && cpu.write && is_hram;

        bus.wdata = cpu.wdata;
        if (state_q == DmaActive) begin
            bus.addr   = {dma_src_eff(dma_src_q), idx_q};
            bus.enable = 1'b1;
            bus.write  = 1'b0;
        end else if (dma_active) begin
            bus.addr   = cpu.addr;
            bus.enable = 1'b0;
            bus.write  = 1'b0;
        end else begin
            bus.addr   = cpu.addr;
            bus.enable = cpu.enable && is_bus;
            bus.write  = cpu.enable && cpu.write && is_bus;
        end

        if (is_dma_reg) begin
            cpu.rdata = dma_src_q;
        end else if (is_hram) begin
            cpu.rdata = hram_rdata;
        end else if (dma_active) begin
            cpu.rdata = 8'hFF;
        end else begin
            cpu.rdata = bus.rdata;
        end

        oam_write = (state_q == DmaActive) && m_end && !reset;
        oam_addr  = idx_q;
        oam_wdata = bus.rdata;
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: scoreboard of expected OAM writes plus
// per-M-cycle checks of CPU-visible routing and blocking.
module tb_oam_dma_arbiter;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] t_cycle = 2'd0;

    oam_dma_arbiter_if cpu_if ();
    oam_dma_arbiter_if bus_if ();

    logic [6:0] hram_addr;
    logic       hram_enable;
    logic       hram_write;
    logic [7:0] hram_rdata;
    logic [7:0] oam_addr;
    logic       oam_write;
    logic [7:0] oam_wdata;
    logic       dma_active;

    logic [7:0] hram_mem [128];

    always #5 clk = ~clk;

    oam_dma_arbiter #(.OAM_LEN(160)) dut (
        .clk         (clk),
        .reset       (reset),
        .t_cycle     (t_cycle),
        .cpu         (cpu_if),
        .bus         (bus_if),
        .hram_addr   (hram_addr),
        .hram_enable (hram_enable),
        .hram_write  (hram_write),
        .hram_rdata  (hram_rdata),
        .oam_addr    (oam_addr),
        .oam_write   (oam_write),
        .oam_wdata   (oam_wdata),
        .dma_active  (dma_active)
    );

    // Bus memory: byte = lo ^ hi ^ 0x9B, so 0xC1xx holds i ^ 0x5A.
    assign bus_if.rdata = bus_if.addr[7:0] ^ bus_if.addr[15:8] ^ 8'h9B;
    assign hram_rdata   = hram_mem[hram_addr];

    always @(posedge clk) begin
        if (hram_write && t_cycle == 2'd3) hram_mem[hram_addr] <= bus_if.wdata;
    end

    typedef struct packed {
        logic [7:0]  addr;
        logic [7:0]  data;
        logic [15:0] baddr;
    } oam_exp_t;

    oam_exp_t exp_q[$];
    oam_exp_t mon_e;
    int n_checks = 0;
    int n_pass = 0;

    logic [7:0] s_rdata;
    logic       s_dact;
    logic       s_ben_any;
    logic       s_bwr_any;
    logic       pulse_reset = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, req);
    endtask

    task automatic push_xfer(input logic [7:0] src_eff, input logic [7:0] key, input int count);
        for (int i = 0; i < count; i++) begin
            exp_q.push_back('{addr: 8'(i), data: 8'(i) ^ key, baddr: {src_eff, 8'(i)}});
        end
    endtask

    // One M-cycle: inputs change just after a posedge, outputs sampled at negedge.
    task automatic mcycle(input logic [15:0] a, input logic en, input logic wr,
                          input logic [7:0] wd);
        s_ben_any = 1'b0;
        s_bwr_any = 1'b0;
        for (int p = 0; p < 4; p++) begin
            t_cycle       = 2'(p);
            cpu_if.addr   = a;
            cpu_if.enable = en;
            cpu_if.write  = wr;
            cpu_if.wdata  = wd;
            if (pulse_reset) reset = (p == 0);
            @(negedge clk);
            s_ben_any = s_ben_any | bus_if.enable;
            s_bwr_any = s_bwr_any | bus_if.write;
            if (p == 3) begin
                s_rdata = cpu_if.rdata;
                s_dact  = dma_active;
            end
            @(posedge clk);
            #1;
        end
        pulse_reset = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) mcycle(16'h0000, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        mcycle(a, 1'b1, 1'b1, d);
    endtask

    task automatic cpu_rd(input logic [15:0] a);
        mcycle(a, 1'b1, 1'b0, 8'h00);
    endtask

    always @(negedge clk) begin
        if (!reset && oam_write) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL oam_unexpected: got write addr %h data %h, required none",
                         oam_addr, oam_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("oam_addr", 16'(oam_addr), 16'(mon_e.addr));
                check("oam_wdata", 16'(oam_wdata), 16'(mon_e.data));
                check("oam_bus_addr", bus_if.addr, mon_e.baddr);
                check("oam_t_cycle", 16'(t_cycle), 16'd3);
            end
        end
    end

    initial begin
        cpu_if.addr   = 16'h0000;
        cpu_if.enable = 1'b0;
        cpu_if.write  = 1'b0;
        cpu_if.wdata  = 8'h00;
        @(posedge clk);
        #1;
        idle(2);
        reset = 1'b0;

        // Reset state
        cpu_rd(DMA_REG_ADDR);
        check("rst_dma_src", 16'(s_rdata), 16'h00FF);
        check("rst_dma_active", 16'(s_dact), 16'h0000);
        check("rst_reg_bus_en", 16'(s_ben_any), 16'h0000);

        // Register write/read never reach the bus
        cpu_wr(DMA_REG_ADDR, 8'h80);
        check("reg_wr_bus_en", 16'(s_ben_any), 16'h0000);
        push_xfer(8'h80, 8'h1B, 160);
        cpu_rd(DMA_REG_ADDR);
        check("reg_rd_data", 16'(s_rdata), 16'h0080);
        check("reg_rd_bus_en", 16'(s_ben_any), 16'h0000);
        check("setup_dma_active", 16'(s_dact), 16'h0000);
        idle(160);

        // Transfer from 0xC100 with CPU activity during ACTIVE
        cpu_wr(DMA_REG_ADDR, 8'hC1);
        push_xfer(8'hC1, 8'h5A, 160);
        idle(1);
        check("c1_setup_inactive", 16'(s_dact), 16'h0000);
        idle(1);
        check("c1_active_rises", 16'(s_dact), 16'h0001);
        cpu_rd(16'h0150);
        check("active_rd_blocked", 16'(s_rdata), 16'h00FF);
        cpu_wr(16'hC000, 8'hA5);
        check("active_wr_dropped", 16'(s_bwr_any), 16'h0000);
        cpu_wr(16'hFF90, 8'h3C);
        cpu_rd(16'hFF90);
        check("active_hram_rd", 16'(s_rdata), 16'h003C);
        idle(154);
        cpu_rd(16'h0150);
        check("last_byte_blocked", 16'(s_rdata), 16'h00FF);
        check("last_byte_active", 16'(s_dact), 16'h0001);
        cpu_rd(16'h0150);
        check("bus_returned_data", 16'(s_rdata), 16'h00CA);
        check("bus_returned_inactive", 16'(s_dact), 16'h0000);
        check("bus_returned_en", 16'(s_ben_any), 16'h0001);

        // Echo-range source
        cpu_wr(DMA_REG_ADDR, 8'hFE);
        push_xfer(8'hDE, 8'h45, 160);
        idle(161);
        cpu_rd(16'h0150);
        check("fe_pass_through", 16'(s_rdata), 16'h00CA);

        // Restart at idx 40
        cpu_wr(DMA_REG_ADDR, 8'hC3);
        push_xfer(8'hC3, 8'h58, 41);
        push_xfer(8'hC2, 8'h59, 160);
        idle(41);
        cpu_wr(DMA_REG_ADDR, 8'hC2);
        cpu_rd(16'h0150);
        check("restart_rd_blocked", 16'(s_rdata), 16'h00FF);
        check("restart_bus_idle", 16'(s_ben_any), 16'h0000);
        check("restart_active", 16'(s_dact), 16'h0001);
        idle(160);
        cpu_rd(16'h0150);
        check("restart_done_data", 16'(s_rdata), 16'h00CA);
        check("restart_done_inactive", 16'(s_dact), 16'h0000);

        // Reset at idx 100
        cpu_wr(DMA_REG_ADDR, 8'hC1);
        push_xfer(8'hC1, 8'h5A, 100);
        idle(101);
        pulse_reset = 1'b1;
        idle(1);
        check("reset_dma_active", 16'(s_dact), 16'h0000);
        idle(3);
        cpu_rd(DMA_REG_ADDR);
        check("reset_dma_src", 16'(s_rdata), 16'h00FF);
        cpu_rd(16'h0150);
        check("reset_pass_through", 16'(s_rdata), 16'h00CA);

        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
